// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N one-hot decoder with direct and auto-scan modes
module scan_decoder #(
  parameter int N          = 3,
  parameter int DWELL      = 20,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      a,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap,
  output logic              busy
);

  localparam int M  = 2**N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};
  localparam logic [M-1:0]  Y_IDLE   = (ACTIVE_LOW != 0) ? {M{1'b1}} : {M{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  function automatic logic [M-1:0] drive(input logic [N-1:0] i);
    logic [M-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Next state depends only on en/mode, so every branch also sets that state's outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      y     <= Y_IDLE;
    end else begin
      wrap <= 1'b0;
      cnt  <= '0;
      if (!en) begin
        state <= IDLE;
        busy  <= 1'b0;
        y     <= Y_IDLE;
      end else if (!mode) begin
        state <= DIRECT;
        busy  <= 1'b0;
        idx   <= a;
        y     <= drive(a);
      end else begin
        state <= SCAN;
        busy  <= 1'b1;
        // Entry and load both restart a full dwell; load never flags a wrap.
        if (state != SCAN || load) begin
          idx <= load ? a : idx;
          y   <= drive(load ? a : idx);
        end else if (cnt == CNT_LAST) begin
          idx  <= idx + 1'b1;
          y    <= drive(idx + 1'b1);
          wrap <= (idx == IDX_LAST);
        end else begin
          cnt <= cnt + 1'b1;
          y   <= drive(idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - directed self-checking bench for scan_decoder with a scan-position model
module tb_scan_decoder;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] a = '0;
  logic [7:0] y0, y1;
  logic [2:0] idx0, idx1;
  logic       wrap0, wrap1, busy0, busy1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  scan_decoder #(.N(3), .DWELL(D0), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .a(a),
    .y(y0), .idx(idx0), .wrap(wrap0), .busy(busy0)
  );

  scan_decoder #(.N(3), .DWELL(D1), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .a(a),
    .y(y1), .idx(idx1), .wrap(wrap1), .busy(busy1)
  );

  // Model: scan position pos = idx*D + dwell, walking 0 .. 8*D-1 linearly.
  // m_st: 0 idle, 1 direct, 2 scan.
  int m_pos [2] = '{0, 0};
  int m_st  [2] = '{0, 0};
  bit m_wrap[2] = '{0, 0};

  function automatic int dw(input int g);
    return (g == 0) ? D0 : D1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        m_st[g] <= 0; m_pos[g] <= 0; m_wrap[g] <= 1'b0;
      end else if (!en) begin
        m_st[g] <= 0; m_pos[g] <= (m_pos[g] / dw(g)) * dw(g); m_wrap[g] <= 1'b0;
      end else if (!mode) begin
        m_st[g] <= 1; m_pos[g] <= int'(a) * dw(g); m_wrap[g] <= 1'b0;
      end else if (m_st[g] != 2 || load) begin
        m_st[g] <= 2;
        m_pos[g] <= load ? int'(a) * dw(g) : (m_pos[g] / dw(g)) * dw(g);
        m_wrap[g] <= 1'b0;
      end else begin
        m_st[g] <= 2;
        m_pos[g] <= (m_pos[g] + 1) % (dw(g) * 8);
        m_wrap[g] <= ((m_pos[g] + 1) % (dw(g) * 8)) == 0;
      end
    end
  end

  function automatic logic [7:0] exp_y(input int g);
    logic [7:0] v;
    v = '0;
    if (m_st[g] != 0) v[m_pos[g] / dw(g)] = 1'b1;
    return (g == 1) ? ~v : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_y0",    32'(y0),    32'(exp_y(0)));
      check("model_idx0",  32'(idx0),  32'(m_pos[0] / D0));
      check("model_wrap0", 32'(wrap0), 32'(m_wrap[0]));
      check("model_busy0", 32'(busy0), 32'(m_st[0] == 2));
      check("model_y1",    32'(y1),    32'(exp_y(1)));
      check("model_idx1",  32'(idx1),  32'(m_pos[1] / D1));
      check("model_wrap1", 32'(wrap1), 32'(m_wrap[1]));
      check("model_busy1", 32'(busy1), 32'(m_st[1] == 2));
    end
  end

  task automatic wait_idx0(input logic [2:0] v);
    int n;
    n = 0;
    while (idx0 !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (idx0 !== v) check("wait_idx0_timeout", 32'(idx0), 32'(v));
  endtask

  logic [7:0] dir_tab  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [2:0] scan_tab [9] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
  logic [7:0] al_tab   [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};

  initial begin
    @(negedge clk);
    check("rst_y0",    32'(y0),    32'h00);
    check("rst_idx0",  32'(idx0),  32'h0);
    check("rst_busy0", 32'(busy0), 32'h0);
    check("rst_wrap0", 32'(wrap0), 32'h0);
    check("rst_y1",    32'(y1),    32'hFF);
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; chk_en = 1'b1;

    for (int k = 0; k < 8; k++) begin
      a = 3'(k);
      @(negedge clk);
      check("direct_y0", 32'(y0), 32'(dir_tab[k]));
    end

    mode = 1'b1; load = 1'b1; a = 3'd6;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      load = 1'b0;
      check("scan_idx0",  32'(idx0),  32'(scan_tab[i]));
      check("scan_wrap0", 32'(wrap0), 32'(i == 8));
      check("scan_busy0", 32'(busy0), 32'h1);
    end

    wait_idx0(3'd7);
    repeat (3) @(negedge clk);
    load = 1'b1; a = 3'd2;
    @(negedge clk);
    load = 1'b0;
    check("loadpri_idx0",  32'(idx0),  32'h2);
    check("loadpri_wrap0", 32'(wrap0), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("loadpri_hold", 32'(idx0), 32'h2);
    end
    @(negedge clk);
    check("loadpri_next", 32'(idx0), 32'h3);

    wait_idx0(3'd7);
    repeat (3) @(negedge clk);
    load = 1'b1; a = 3'd0;
    @(negedge clk);
    load = 1'b0;
    check("load0_idx0",  32'(idx0),  32'h0);
    check("load0_wrap0", 32'(wrap0), 32'h0);

    wait_idx0(3'd5);
    en = 1'b0;
    @(negedge clk);
    check("en_off_y0",    32'(y0),    32'h00);
    check("en_off_idx0",  32'(idx0),  32'h5);
    check("en_off_busy0", 32'(busy0), 32'h0);
    en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("resume_idx0",  32'(idx0),  32'h5);
      check("resume_busy0", 32'(busy0), 32'h1);
    end
    @(negedge clk);
    check("resume_next", 32'(idx0), 32'h6);
    mode = 1'b0; a = 3'd3;
    @(negedge clk);
    check("mode_direct_y0",  32'(y0),    32'h08);
    check("mode_direct_bsy", 32'(busy0), 32'h0);

    mode = 1'b1; load = 1'b1; a = 3'd4;
    @(negedge clk);
    load = 1'b0;
    check("pre_rst_idx0", 32'(idx0), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y0",    32'(y0),    32'h00);
    check("arst_idx0",  32'(idx0),  32'h0);
    check("arst_wrap0", 32'(wrap0), 32'h0);
    check("arst_busy0", 32'(busy0), 32'h0);
    check("arst_y1",    32'(y1),    32'hFF);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("al_y1",    32'(y1),    32'(al_tab[i]));
      check("al_wrap1", 32'(wrap1), 32'(i == 8));
    end

    en = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
